aes_mixcolumns_iter: RTL
========================

// Module: aes_mixcolumns_iter
// PURPOSE
//  Iterative, handshaked AES (Inverse)MixColumns over a full 128-bit state.
//  Processes COLS_PER_CYCLE columns per cycle from a registered state, so area
//  trades against latency. Supports forward, inverse and constant-time bypass
//  modes. Sits between SubBytes/ShiftRows and AddRoundKey in the round datapath.
// PARAMETERS
//  COLS_PER_CYCLE  1   columns mixed per RUN cycle; legal 1, 2, 4 (else elaboration error)
//  NCYC            4/COLS_PER_CYCLE  derived localparam, RUN cycles per state
// PORTS
//  g_clk      in   1    clock; all state changes on rising edge
//  g_rst      in   1    synchronous, active-high reset
//  in_valid   in   1    in_state/in_dec/in_bypass valid
//  in_ready   out  1    block can accept a state
//  in_state   in   128  column i = in_state[32*i+31:32*i]; row r byte = bits [8r+7:8r]
//  in_dec     in   1    1 = InvMixColumns, 0 = MixColumns
//  in_bypass  in   1    1 = pass state through unchanged (final round), same latency
//  out_valid  out  1    out_state holds result
//  out_ready  in   1    consumer accepts out_state
//  out_state  out  128  result, same column/byte layout as in_state
//  busy       out  1    high in RUN or DONE
// BEHAVIOUR
//  - Reset: FSM=IDLE, in_ready=1, out_valid=0, busy=0, out_state=0, column counter=0.
//    Reset mid-operation aborts the transfer; no output is produced for it.
//  - FSM: IDLE -(in_valid&in_ready)-> RUN -(counter==NCYC-1)-> DONE -(out_ready)-> IDLE.
//  - in_ready = (FSM==IDLE). Accept edge latches in_state, in_dec, in_bypass.
//    in_* ignored outside IDLE.
//  - RUN: each cycle columns [k*C .. k*C+C-1] (C=COLS_PER_CYCLE, k=counter) are
//    replaced in the state register; other columns hold. counter wraps to 0 on exit.
//  - Latency: out_valid rises exactly NCYC cycles after the accept edge,
//    independent of data, in_dec or in_bypass (constant time).
//  - DONE: out_valid=1, out_state stable until out_valid&out_ready edge;
//    next edge is IDLE (out_valid=0). Earliest re-accept is one cycle after that;
//    no overlap of input and output transfers.
//  - Arithmetic, GF(2^8) mod x^8+x^4+x^3+x+1 (xtime: (a<<1)^(a[7]?8'h1b:0)), for
//    column bytes a0..a3, row r output:
//      enc: o_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3)
//      dec: o_r = e*a_r ^ b*a_(r+1) ^ d*a_(r+2) ^ 9*a_(r+3)   (indices mod 4)
//      bypass: o_r = a_r.
//  - out_state reflects partially mixed data during RUN; only meaningful with out_valid.
//  - out_ready while not DONE has no effect.
// TESTING
//  1 Enc, each column 32'h455313db (bytes db,13,53,45), COLS=1 -> after 4 cycles
//    out_valid=1, every column 32'hbca14d8e.
//  2 Dec, columns {5c220af2 -> expected 9d58dc9f inverse}: in 32'h9d58dc9f x4
//    -> 32'h5c220af2 x4; round-trip enc then dec of random state returns input.
//  3 Identity: columns 01010101 and c6c6c6c6, enc and dec -> unchanged; bypass of
//    random state -> identical output, latency still NCYC.
//  4 Backpressure: out_ready=0 for 10 cycles in DONE -> out_state stable, in_ready=0,
//    new in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
//  5 Reset at RUN counter=1 -> next cycle IDLE, out_valid=0, out_state=0; following
//    transfer produces correct result.
//  6 Sweep COLS_PER_CYCLE=1,2,4 with 1000 random states/modes vs software model:
//    latency 4/2/1 cycles, results bit-exact.

Source files
------------

// File: rtl/aes_mixcolumns_iter.sv
// Iterative AES MixColumns / InvMixColumns / bypass over a 128-bit state.
// COLS_PER_CYCLE columns are rewritten in place per RUN cycle, so latency is constant.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for in_valid, in_ready high
//   RUN   | mixing column group r_cnt, NCYC cycles regardless of mode
//   DONE  | result held on out_state until out_ready
module aes_mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         g_clk,
    input  logic         g_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_dec,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int         NCYC     = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_CNT = 2'(NCYC - 1);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("aes_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       r_fsm, w_fsm_nxt;
    logic [1:0]   r_cnt;
    logic [127:0] r_state;
    logic [127:0] w_mixed;
    logic         r_dec;
    logic         r_bypass;
    logic         w_accept;
    logic         w_last;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // All three results are always computed so timing does not depend on mode.
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic dec, input logic byp);
        logic [7:0]  a [4];
        logic [7:0]  m2 [4];
        logic [7:0]  m4 [4];
        logic [7:0]  m8 [4];
        logic [31:0] enc_r, dec_r;
        for (int r = 0; r < 4; r++) begin
            a[r]  = c[8*r +: 8];
            m2[r] = xt(a[r]);
            m4[r] = xt(m2[r]);
            m8[r] = xt(m4[r]);
        end
        for (int r = 0; r < 4; r++) begin
            enc_r[8*r +: 8] = m2[r] ^ (m2[(r+1)%4] ^ a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
            dec_r[8*r +: 8] = (m8[r] ^ m4[r] ^ m2[r])
                            ^ (m8[(r+1)%4] ^ m2[(r+1)%4] ^ a[(r+1)%4])
                            ^ (m8[(r+2)%4] ^ m4[(r+2)%4] ^ a[(r+2)%4])
                            ^ (m8[(r+3)%4] ^ a[(r+3)%4]);
        end
        return byp ? c : (dec ? dec_r : enc_r);
    endfunction

    assign w_accept = (r_fsm == IDLE) && in_valid;
    assign w_last   = (r_cnt == LAST_CNT);

    always_comb begin
        w_mixed = r_state;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            logic [1:0] idx;
            idx = r_cnt * 2'(COLS_PER_CYCLE) + 2'(j);
            w_mixed[{idx, 5'b0} +: 32] = mix_col(r_state[{idx, 5'b0} +: 32], r_dec, r_bypass);
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) r_fsm <= IDLE;
        else       r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_fsm_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_fsm_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_fsm_nxt = IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            r_state  <= '0;
            r_cnt    <= '0;
            r_dec    <= 1'b0;
            r_bypass <= 1'b0;
        end else if (w_accept) begin
            r_state  <= in_state;
            r_dec    <= in_dec;
            r_bypass <= in_bypass;
            r_cnt    <= '0;
        end else if (r_fsm == RUN) begin
            r_state <= w_mixed;
            r_cnt   <= w_last ? 2'd0 : r_cnt + 2'd1;
        end
    end

    assign out_state = r_state;

endmodule
